// File: rtl/systolic_pkg.sv
// systolic_pkg: shared types and saturating add for the systolic PE family.
package systolic_pkg;
    typedef enum logic [1:0] {
        W_EMPTY   = 2'b00,
        W_SHD     = 2'b01,
        W_ACT     = 2'b10,
        W_ACT_SHD = 2'b11
    } wstate_e;

    localparam int ERR_SWAP = 0;
    localparam int ERR_COLL = 1;
    localparam int ERR_SAT  = 2;
    localparam int SAT_W    = 64;

    typedef struct packed {
        logic signed [SAT_W-1:0] sum;
        logic                    ovf;
    } sat_t;

    // Operands must already lie in the signed w-bit range; the sum is clamped to it.
    function automatic sat_t sat_add(input logic signed [SAT_W-1:0] a,
                                     input logic signed [SAT_W-1:0] b,
                                     input int unsigned w);
        logic signed [SAT_W-1:0] s, hi;
        sat_t r;
        s = a + b;
        hi = $signed((SAT_W'(1) << (w - 1)) - SAT_W'(1));
        r.ovf = s > hi || s < ~hi;
        r.sum = r.ovf ? (s > hi ? hi : ~hi) : s;
        return r;
    endfunction
endpackage

// File: rtl/pe_dot_lanes.sv
// pe_dot_lanes: combinational LANES-wide signed dot product at full precision.
module pe_dot_lanes #(
    parameter int BW_ACT = 8,
    parameter int BW_WET = 8,
    parameter int LANES  = 1,
    parameter int DW     = BW_ACT + BW_WET + $clog2(LANES)
) (
    input  logic [LANES*BW_ACT-1:0] act,
    input  logic [LANES*BW_WET-1:0] wet,
    output logic signed [DW-1:0]    dot
);
    localparam int PW = BW_ACT + BW_WET;

    logic signed [PW-1:0] prod [LANES];

    always_comb begin
        dot = '0;
        for (int l = 0; l < LANES; l++) begin
            prod[l] = PW'($signed(act[l*BW_ACT +: BW_ACT])) * PW'($signed(wet[l*BW_WET +: BW_WET]));
            dot = dot + DW'(prod[l]);
        end
    end
endmodule

// File: rtl/systolic_pe_dp.sv
// systolic_pe_dp: weight-stationary dot-product PE with double-buffered weights
// sharing the vertical psum path, plus sticky error flags.
module systolic_pe_dp
    import systolic_pkg::*;
#(
    parameter int BW_ACT    = 8,
    parameter int BW_WET    = 8,
    parameter int BW_ACCU   = 32,
    parameter int LANES     = 1,
    parameter int FIRST_ROW = 0,
    parameter int SATURATE  = 0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    pe_valid_i,
    input  logic [LANES*BW_ACT-1:0] pe_act_i,
    input  logic [BW_ACCU-1:0]      pe_above_i,
    input  logic                    pe_wload_i,
    input  logic                    pe_wswap_i,
    input  logic                    pe_wclear_i,
    input  logic                    pe_err_clr_i,
    output logic [LANES*BW_ACT-1:0] pe_act_o,
    output logic                    pe_valid_o,
    output logic [BW_ACCU-1:0]      pe_below_o,
    output logic                    pe_below_vld_o,
    output logic                    pe_wload_o,
    output logic [2:0]              pe_err_o
);
    localparam int WW = LANES * BW_WET;
    localparam int DW = BW_ACT + BW_WET + $clog2(LANES);

    wstate_e                 wst;
    logic [WW-1:0]           w_act, w_shd;
    logic signed [DW-1:0]    dot;
    logic signed [SAT_W-1:0] seed;
    sat_t                    add;
    logic [BW_ACCU-1:0]      mac;
    logic [2:0]              err_set;
    logic                    act_vld, shd_vld, swap_ok;

    pe_dot_lanes #(.BW_ACT(BW_ACT), .BW_WET(BW_WET), .LANES(LANES), .DW(DW)) u_dot (
        .act(pe_act_i),
        .wet(w_act),
        .dot(dot)
    );

    assign act_vld = wst[1];
    assign shd_vld = wst[0];
    assign swap_ok = pe_wswap_i & shd_vld;
    assign seed    = FIRST_ROW != 0 ? '0 : SAT_W'($signed(pe_above_i));
    assign add     = sat_add(seed, SAT_W'(dot), BW_ACCU);
    assign mac     = SATURATE != 0 ? add.sum[BW_ACCU-1:0] : BW_ACCU'(seed + SAT_W'(dot));

    always_comb begin
        err_set           = '0;
        err_set[ERR_SWAP] = pe_wswap_i & ~shd_vld & ~pe_wclear_i;
        err_set[ERR_COLL] = pe_valid_i & pe_wload_i;
        err_set[ERR_SAT]  = SATURATE != 0 && pe_valid_i && !pe_wload_i && add.ovf;
    end

    // Swap reads the old shadow before a same-cycle load overwrites it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wst   <= W_EMPTY;
            w_act <= '0;
            w_shd <= '0;
        end else if (pe_wclear_i) begin
            wst   <= W_EMPTY;
            w_act <= '0;
            w_shd <= '0;
        end else begin
            if (swap_ok) w_act <= w_shd;
            if (pe_wload_i) w_shd <= pe_above_i[WW-1:0];
            wst <= wstate_e'({act_vld | swap_ok, pe_wload_i | (shd_vld & ~swap_ok)});
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pe_act_o       <= '0;
            pe_valid_o     <= 1'b0;
            pe_below_o     <= '0;
            pe_below_vld_o <= 1'b0;
            pe_wload_o     <= 1'b0;
            pe_err_o       <= '0;
        end else begin
            if (pe_valid_i) pe_act_o <= pe_act_i;
            pe_valid_o     <= pe_valid_i;
            pe_wload_o     <= pe_wload_i;
            pe_below_o     <= pe_wload_i ? pe_above_i : pe_valid_i ? mac : '0;
            pe_below_vld_o <= pe_valid_i & ~pe_wload_i;
            pe_err_o       <= (pe_err_o & ~{3{pe_err_clr_i}}) | err_set;
        end
    end
endmodule

// File: tb/tb_systolic_pe_dp.sv
// tb_systolic_pe_dp: three PE configurations (saturating chain, wrapping chain,
// wrapping first row) driven in lock-step and checked against a behavioural model.
module tb_systolic_pe_dp;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        v = 1'b0, wl = 1'b0, sw = 1'b0, wc = 1'b0, ec = 1'b0;
    logic [15:0] act = '0, above = '0;

    logic [15:0] act_o [3];
    logic [15:0] below [3];
    logic        val_o [3];
    logic        bv    [3];
    logic        wlo   [3];
    logic [2:0]  err   [3];

    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g
        systolic_pe_dp #(
            .BW_ACT(8), .BW_WET(8), .BW_ACCU(16), .LANES(2),
            .FIRST_ROW(k == 2 ? 1 : 0), .SATURATE(k == 0 ? 1 : 0)
        ) u (
            .clk(clk), .reset_n(reset_n),
            .pe_valid_i(v), .pe_act_i(act), .pe_above_i(above),
            .pe_wload_i(wl), .pe_wswap_i(sw), .pe_wclear_i(wc), .pe_err_clr_i(ec),
            .pe_act_o(act_o[k]), .pe_valid_o(val_o[k]), .pe_below_o(below[k]),
            .pe_below_vld_o(bv[k]), .pe_wload_o(wlo[k]), .pe_err_o(err[k])
        );
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Model: weights as integer lanes, psum as plain integer arithmetic.
    int          wa [2], ws [2];
    bit          av, sv;
    logic [15:0] e_act;
    bit          e_val, e_wl;
    logic [15:0] e_bel [3];
    bit          e_bv  [3];
    logic [2:0]  e_err [3];
    int          m_dot, m_seed, m_s, m_res;
    bit          m_ovf;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wa = '{0, 0}; ws = '{0, 0}; av = 0; sv = 0;
            e_act = '0; e_val = 0; e_wl = 0;
            for (int k = 0; k < 3; k++) begin
                e_bel[k] = '0; e_bv[k] = 0; e_err[k] = '0;
            end
        end else begin
            m_dot = int'($signed(act[7:0])) * wa[0] + int'($signed(act[15:8])) * wa[1];
            for (int k = 0; k < 3; k++) begin
                m_seed = k == 2 ? 0 : int'($signed(above));
                m_s = m_seed + m_dot;
                m_ovf = k == 0 && (m_s > 32767 || m_s < -32768);
                m_res = !m_ovf ? m_s : m_s > 0 ? 32767 : -32768;
                e_bel[k] = wl ? above : v ? 16'(m_res) : 16'd0;
                e_bv[k] = v && !wl;
                e_err[k] = (ec ? 3'b000 : e_err[k])
                         | {m_ovf && v && !wl, v && wl, sw && !sv && !wc};
            end
            e_val = v; e_wl = wl;
            if (v) e_act = act;
            if (wc) begin
                wa = '{0, 0}; ws = '{0, 0}; av = 0; sv = 0;
            end else begin
                if (sw && sv) begin
                    wa = ws; av = 1; sv = 0;
                end
                if (wl) begin
                    ws[0] = int'($signed(above[7:0]));
                    ws[1] = int'($signed(above[15:8]));
                    sv = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("below%0d", k), below[k], e_bel[k]);
            chk($sformatf("bvld%0d", k), bv[k], e_bv[k]);
            chk($sformatf("err%0d", k), err[k], e_err[k]);
            chk($sformatf("act_o%0d", k), act_o[k], e_act);
            chk($sformatf("valid_o%0d", k), val_o[k], e_val);
            chk($sformatf("wload_o%0d", k), wlo[k], e_wl);
        end
    end

    // Inputs are consumed by the next rising edge; returns 1 time unit after it.
    task automatic drive(input logic iv, input logic iwl, input logic isw, input logic iwc,
                         input logic iec, input logic [15:0] iact, input logic [15:0] iab);
        v = iv; wl = iwl; sw = isw; wc = iwc; ec = iec; act = iact; above = iab;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 16'h0000, 16'h0000);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        chk("rst_below", below[0], 16'h0000);
        chk("rst_err", err[0], 3'b000);

        // T3: swap with no shadow, MAC on zero weights
        drive(0, 0, 1, 0, 0, 16'h0000, 16'h0000);
        chk("t3_err0", err[0], 3'b001);
        drive(1, 0, 0, 0, 0, 16'h0504, 16'd123);
        chk("t3_seed", below[0], 16'd123);
        chk("t3_seed_fr", below[2], 16'd0);
        chk("t3_vld", bv[0], 1'b1);
        drive(0, 0, 0, 0, 1, 16'h0000, 16'h0000);
        chk("t3_clr", err[0], 3'b000);

        // T1: {w1=3, w0=-2} . {5, 4} = 7
        drive(0, 1, 0, 0, 0, 16'h0000, 16'h03FE);
        chk("t1_fwd", below[1], 16'h03FE);
        drive(0, 0, 1, 0, 0, 16'h0000, 16'h0000);
        drive(1, 0, 0, 0, 0, 16'h0504, 16'h0000);
        chk("t1_mac", below[2], 16'd7);
        chk("t1_mac_chain", below[0], 16'd7);
        idle();

        // T2: overlap load/swap with streaming
        drive(0, 1, 0, 0, 0, 16'h0000, 16'h0101);
        drive(0, 0, 1, 0, 0, 16'h0000, 16'h0000);
        drive(1, 0, 0, 0, 0, 16'h0203, 16'd1000);
        chk("t2_old", below[2], 16'd5);
        chk("t2_old_chain", below[1], 16'd1005);
        drive(1, 1, 0, 0, 0, 16'h0203, 16'h0202);
        chk("t2_coll_vld", bv[0], 1'b0);
        chk("t2_coll_err", err[1], 3'b010);
        chk("t2_coll_fwd", below[0], 16'h0202);
        drive(1, 0, 0, 0, 0, 16'h0203, 16'h0000);
        chk("t2_still_old", below[2], 16'd5);
        drive(1, 0, 1, 0, 0, 16'h0203, 16'h0000);
        chk("t2_swap_cyc", below[2], 16'd5);
        drive(1, 0, 0, 0, 0, 16'h0203, 16'h0000);
        chk("t2_new", below[2], 16'd10);
        drive(0, 0, 0, 0, 1, 16'h0000, 16'h0000);

        // T4: 32760 + 100 saturates / wraps
        drive(0, 1, 0, 0, 0, 16'h0000, 16'h000A);
        drive(0, 0, 1, 0, 0, 16'h0000, 16'h0000);
        drive(1, 0, 0, 0, 0, 16'h000A, 16'd32760);
        chk("t4_sat", below[0], 16'h7FFF);
        chk("t4_sat_err", err[0], 3'b100);
        chk("t4_wrap", below[1], 16'h805C);
        chk("t4_wrap_err", err[1], 3'b000);
        chk("t4_fr", below[2], 16'd100);
        drive(1, 0, 0, 0, 0, 16'h00F6, 16'h8005);
        chk("t4_sat_neg", below[0], 16'h8000);
        drive(0, 0, 0, 0, 1, 16'h0000, 16'h0000);
        chk("t4_clr", err[0], 3'b000);

        // T5: wclear beats simultaneous wload+swap
        drive(0, 1, 0, 0, 0, 16'h0000, 16'h0505);
        drive(0, 1, 1, 1, 0, 16'h0000, 16'h0707);
        drive(1, 0, 0, 0, 0, 16'h0101, 16'd55);
        chk("t5_seed", below[0], 16'd55);
        chk("t5_seed_fr", below[2], 16'd0);
        drive(0, 0, 1, 0, 0, 16'h0000, 16'h0000);
        chk("t5_empty", err[0], 3'b001);
        drive(0, 0, 0, 0, 1, 16'h0000, 16'h0000);

        // T6: asynchronous reset during a valid burst
        drive(0, 1, 0, 0, 0, 16'h0000, 16'h0101);
        drive(0, 0, 1, 0, 0, 16'h0000, 16'h0000);
        drive(1, 0, 0, 0, 0, 16'h0102, 16'd7);
        drive(1, 1, 0, 0, 0, 16'h0102, 16'h0101);
        drive(1, 0, 0, 0, 0, 16'h0102, 16'd7);
        chk("t6_pre", below[2], 16'd3);
        #2 reset_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t6_below%0d", k), below[k], 16'h0000);
            chk($sformatf("t6_valid%0d", k), val_o[k], 1'b0);
            chk($sformatf("t6_act%0d", k), act_o[k], 16'h0000);
            chk($sformatf("t6_err%0d", k), err[k], 3'b000);
        end
        @(posedge clk);
        #3 reset_n = 1'b1;
        drive(1, 0, 0, 0, 0, 16'h0303, 16'd9);
        chk("t6_post", below[0], 16'd9);
        chk("t6_post_fr", below[2], 16'd0);
        idle();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
